// File: rtl/memory_stage_pipelined.sv
// Memory stage: registers execute results, runs the data-memory req/ack access
// for loads/stores, and presents one registered writeback word per instruction.
module memory_stage_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_ex,
  input  logic        done_ex,
  input  logic [13:0] control_word_ex,
  input  logic [31:0] ALU_result,
  input  logic [31:0] calculated_adr,
  input  logic [31:0] regfileb_ex,
  output logic        stall_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_mem,
  output logic        rf_wb_mem,
  output logic [4:0]  rd_mem,
  output logic [31:0] wb_data,
  output logic        misaligned_mem
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      r_state;
  logic        r_is_load;
  logic        r_rf_wb;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_pend;
  logic        r_pend_rf;
  logic        r_pend_mis;
  logic [4:0]  r_pend_rd;
  logic [31:0] r_pend_data;

  logic        w_rf_wb, w_mem_we, w_is_load, w_is_mem, w_misal;
  logic [1:0]  w_wb_src, w_off;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic        w_accept, w_start, w_direct, w_ack_done;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_lane, w_ld_data;
  logic        w_unused_cw;

  assign w_rf_wb     = control_word_ex[12];
  assign w_mem_we    = control_word_ex[11];
  assign w_wb_src    = control_word_ex[10:9];
  assign w_rd        = control_word_ex[7:3];
  assign w_f3        = control_word_ex[2:0];
  assign w_off       = calculated_adr[1:0];
  assign w_unused_cw = control_word_ex[13] ^ control_word_ex[8];

  assign w_is_load = ~w_mem_we & (w_wb_src == 2'b01);
  assign w_is_mem  = w_mem_we | w_is_load;
  assign w_misal   = w_is_mem & (((w_f3[1:0] == 2'b01) & w_off[0]) |
                                 (w_f3[1] & (w_off != 2'b00)));

  assign stall_ex   = (r_state == S_ACCESS) & ~dmem_ack;
  assign w_ack_done = (r_state == S_ACCESS) & dmem_ack;
  assign w_accept   = valid_ex & done_ex & ~stall_ex;
  assign w_start    = w_accept & w_is_mem & ~w_misal;
  assign w_direct   = w_accept & ~w_start;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = regfileb_ex;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{regfileb_ex[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{regfileb_ex[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lane = dmem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ld_data = {24'b0, w_lane[7:0]};
      3'b101:  w_ld_data = {16'b0, w_lane[15:0]};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  // A non-access result accepted while another result leaves on the same edge
  // (memory completion or an earlier held result) is held one cycle in r_pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_is_load      <= 1'b0;
      r_rf_wb        <= 1'b0;
      r_rd           <= '0;
      r_funct3       <= '0;
      r_off          <= '0;
      r_pend         <= 1'b0;
      r_pend_rf      <= 1'b0;
      r_pend_mis     <= 1'b0;
      r_pend_rd      <= '0;
      r_pend_data    <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      valid_mem      <= 1'b0;
      rf_wb_mem      <= 1'b0;
      misaligned_mem <= 1'b0;
      rd_mem         <= '0;
      wb_data        <= '0;
    end else begin
      valid_mem      <= 1'b0;
      rf_wb_mem      <= 1'b0;
      misaligned_mem <= 1'b0;
      r_pend         <= 1'b0;

      if (w_ack_done) begin
        valid_mem <= 1'b1;
        rf_wb_mem <= r_is_load & r_rf_wb;
        rd_mem    <= r_rd;
        wb_data   <= w_ld_data;
        dmem_req  <= 1'b0;
        r_state   <= S_IDLE;
      end else if (r_pend) begin
        valid_mem      <= 1'b1;
        rf_wb_mem      <= r_pend_rf;
        misaligned_mem <= r_pend_mis;
        rd_mem         <= r_pend_rd;
        wb_data        <= r_pend_data;
      end else if (w_direct) begin
        valid_mem      <= 1'b1;
        rf_wb_mem      <= w_rf_wb & ~w_is_mem;
        misaligned_mem <= w_misal;
        rd_mem         <= w_rd;
        wb_data        <= ALU_result;
      end

      if (w_direct & (w_ack_done | r_pend)) begin
        r_pend      <= 1'b1;
        r_pend_rf   <= w_rf_wb & ~w_is_mem;
        r_pend_mis  <= w_misal;
        r_pend_rd   <= w_rd;
        r_pend_data <= ALU_result;
      end

      if (w_start) begin
        r_state    <= S_ACCESS;
        dmem_req   <= 1'b1;
        dmem_we    <= w_mem_we;
        dmem_addr  <= {calculated_adr[31:2], 2'b00};
        dmem_be    <= w_be;
        dmem_wdata <= w_wdata;
        r_is_load  <= w_is_load;
        r_rf_wb    <= w_rf_wb;
        r_rd       <= w_rd;
        r_funct3   <= w_f3;
        r_off      <= w_off;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_pipelined.sv
// Scoreboard bench for memory_stage_pipelined: expected writebacks queued at
// stimulus time, DUT writebacks captured by a monitor and compared in order.
module tb_memory_stage_pipelined;

  logic        clk = 1'b0, rst = 1'b1, valid_ex = 1'b0, done_ex = 1'b0;
  logic [13:0] control_word_ex = '0;
  logic [31:0] ALU_result = '0, calculated_adr = '0, regfileb_ex = '0;
  logic        stall_ex, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        valid_mem, rf_wb_mem, misaligned_mem;
  logic [4:0]  rd_mem;
  logic [31:0] wb_data;

  typedef struct packed {
    logic        rf;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } wb_t;

  wb_t exp_q[$];
  wb_t got_q[$];
  bit  care_q[$];
  int  n_cmp = 0, n_bad = 0, n_req = 0;

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
  logic [31:0] ld_adr [5] = '{32'h101, 32'h102, 32'h103, 32'h100, 32'h104};
  logic [3:0]  ld_be  [5] = '{4'b0010, 4'b1100, 4'b1000, 4'b0011, 4'b1111};
  logic [31:0] ld_rd  [5] = '{32'h0000_7F00, 32'h8001_1234, 32'hF000_0000, 32'h1234_ABCD, 32'hDEAD_BEEF};
  logic [31:0] ld_exp [5] = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_00F0, 32'h0000_ABCD, 32'hDEAD_BEEF};

  logic [2:0]  st_f3  [3] = '{3'b000, 3'b001, 3'b010};
  logic [31:0] st_adr [3] = '{32'h201, 32'h200, 32'h204};
  logic [31:0] st_dat [3] = '{32'h1234_56EF, 32'hABCD_5678, 32'hCAFE_F00D};
  logic [3:0]  st_be  [3] = '{4'b0010, 4'b0011, 4'b1111};
  logic [31:0] st_wd  [3] = '{32'hEFEF_EFEF, 32'h5678_5678, 32'hCAFE_F00D};

  // misaligned: {we, wb_src, funct3, addr}
  logic        ma_we  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0]  ma_f3  [4] = '{3'b010, 3'b001, 3'b010, 3'b001};
  logic [31:0] ma_adr [4] = '{32'h6, 32'h3, 32'h2, 32'h5};

  memory_stage_pipelined dut (
    .clk(clk), .rst(rst), .valid_ex(valid_ex), .done_ex(done_ex),
    .control_word_ex(control_word_ex), .ALU_result(ALU_result),
    .calculated_adr(calculated_adr), .regfileb_ex(regfileb_ex),
    .stall_ex(stall_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_mem(valid_mem),
    .rf_wb_mem(rf_wb_mem), .rd_mem(rd_mem), .wb_data(wb_data),
    .misaligned_mem(misaligned_mem)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dmem_req) n_req++;
    if (valid_mem) got_q.push_back(wb_t'({rf_wb_mem, rd_mem, wb_data, misaligned_mem}));
  end

  function automatic logic [13:0] cw(input logic rf, input logic we, input logic [1:0] src,
                                     input logic [4:0] rd, input logic [2:0] f3);
    return {1'b0, rf, we, src, 1'b0, rd, f3};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [13:0] c, input logic [31:0] alu, input logic [31:0] adr,
                       input logic [31:0] rfb);
    valid_ex = 1'b1; done_ex = 1'b1;
    control_word_ex = c; ALU_result = alu; calculated_adr = adr; regfileb_ex = rfb;
  endtask

  task automatic idle();
    valid_ex = 1'b0; done_ex = 1'b0;
  endtask

  task automatic push(input wb_t e, input bit care);
    exp_q.push_back(e);
    care_q.push_back(care);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if ({stall_ex, dmem_req, dmem_we, valid_mem, rf_wb_mem, misaligned_mem, dmem_addr,
         dmem_be, dmem_wdata, rd_mem, wb_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%b valid=%b addr=%h be=%b wdata=%h rd=%0d wb=%h, required all 0",
               dmem_req, valid_mem, dmem_addr, dmem_be, dmem_wdata, rd_mem, wb_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    int r0;
    wb_t e, g;
    bit c;
    r0 = n_req;
    push({1'b1, 5'd5, 32'h0000_1234, 1'b0}, 1'b1);
    drive(cw(1'b1, 1'b0, 2'b00, 5'd5, 3'b000), 32'h0000_1234, 32'h0, 32'h0);
    tick(); idle();
    n_cmp++;
    if (valid_mem !== 1'b1) begin n_bad++; $display("FAIL alu_latency: valid_mem=%b required 1", valid_mem); end
    tick();
    n_cmp++;
    if (valid_mem !== 1'b0) begin n_bad++; $display("FAIL alu_pulse: valid_mem=%b required 0", valid_mem); end
    n_cmp++;
    if (n_req != r0) begin n_bad++; $display("FAIL alu_no_req: req cycles=%0d required 0", n_req - r0); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL alu_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL alu_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  task automatic test_done_low();
    wb_t e, g;
    bit c;
    drive(cw(1'b1, 1'b0, 2'b00, 5'd12, 3'b000), 32'hCAFE_0001, 32'h0, 32'h0);
    done_ex = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (got_q.size() != 0 || valid_mem !== 1'b0) begin
      n_bad++; $display("FAIL done_low_hold: results=%0d valid_mem=%b required 0 and 0", got_q.size(), valid_mem);
    end
    push({1'b1, 5'd12, 32'hCAFE_0001, 1'b0}, 1'b1);
    done_ex = 1'b1;
    tick(); idle();
    tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL done_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL done_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  task automatic test_load_lb();
    int stalls;
    wb_t e, g;
    bit c;
    push({1'b1, 5'd7, 32'hFFFF_FF80, 1'b0}, 1'b1);
    drive(cw(1'b1, 1'b0, 2'b01, 5'd7, 3'b000), 32'h0, 32'h103, 32'h0);
    tick(); idle();
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
      n_bad++; $display("FAIL lb_request: req=%b we=%b addr=%h be=%b required 1 0 00000100 1000",
                        dmem_req, dmem_we, dmem_addr, dmem_be);
    end
    stalls = 0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000; end
      #1;
      if (stall_ex) stalls++;
      tick();
    end
    dmem_ack = 1'b0; dmem_rdata = '0;
    n_cmp++;
    if (stalls != 2) begin n_bad++; $display("FAIL lb_stall_cycles: got %0d required 2", stalls); end
    n_cmp++;
    if (valid_mem !== 1'b1 || dmem_req !== 1'b0) begin
      n_bad++; $display("FAIL lb_complete: valid_mem=%b dmem_req=%b required 1 0", valid_mem, dmem_req);
    end
    tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL lb_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL lb_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  task automatic test_loads();
    wb_t e, g;
    bit c;
    for (int i = 0; i < 5; i++) begin
      push({1'b1, 5'(10 + i), ld_exp[i], 1'b0}, 1'b1);
      drive(cw(1'b1, 1'b0, 2'b01, 5'(10 + i), ld_f3[i]), 32'h0, ld_adr[i], 32'h0);
      tick(); idle();
      n_cmp++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, ld_adr[i] & ~32'h3, ld_be[i]}) begin
        n_bad++; $display("FAIL load_req_%0d: req=%b we=%b addr=%h be=%b required be %b",
                          i, dmem_req, dmem_we, dmem_addr, dmem_be, ld_be[i]);
      end
      dmem_ack = 1'b1; dmem_rdata = ld_rd[i];
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
    end
    tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL loads_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL loads_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  task automatic test_stores();
    wb_t e, g;
    bit c;
    push({1'b0, 5'd3, 32'h0, 1'b0}, 1'b0);
    drive(cw(1'b1, 1'b1, 2'b00, 5'd3, 3'b001), 32'h0, 32'h22, 32'hABCD_5678);
    tick(); idle();
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h20, 4'b1100, 32'h5678_5678}) begin
      n_bad++; $display("FAIL sh_request: req=%b we=%b addr=%h be=%b wdata=%h required 1 1 00000020 1100 56785678",
                        dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push({1'b0, 5'(20 + i), 32'h0, 1'b0}, 1'b0);
      drive(cw(1'b1, 1'b1, 2'b00, 5'(20 + i), st_f3[i]), 32'h0, st_adr[i], st_dat[i]);
      tick(); idle();
      n_cmp++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
          {1'b1, 1'b1, st_adr[i] & ~32'h3, st_be[i], st_wd[i]}) begin
        n_bad++; $display("FAIL store_req_%0d: be=%b wdata=%h required %b %h",
                          i, dmem_be, dmem_wdata, st_be[i], st_wd[i]);
      end
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
    end
    tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL stores_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL stores_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  task automatic test_misaligned();
    int r0;
    wb_t e, g;
    bit c;
    for (int i = 0; i < 4; i++) begin
      r0 = n_req;
      push({1'b0, 5'(24 + i), 32'h0, 1'b1}, 1'b0);
      drive(cw(1'b1, ma_we[i], ma_we[i] ? 2'b00 : 2'b01, 5'(24 + i), ma_f3[i]), 32'h0, ma_adr[i], 32'h1);
      tick(); idle();
      n_cmp++;
      if ({valid_mem, misaligned_mem, rf_wb_mem, dmem_req, stall_ex} !== 5'b11000) begin
        n_bad++; $display("FAIL misaligned_%0d: valid=%b mis=%b rf_wb=%b req=%b stall=%b required 1 1 0 0 0",
                          i, valid_mem, misaligned_mem, rf_wb_mem, dmem_req, stall_ex);
      end
      tick();
      n_cmp++;
      if (n_req != r0) begin n_bad++; $display("FAIL misaligned_noreq_%0d: req cycles=%0d required 0", i, n_req - r0); end
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL mis_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL mis_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [3:0] vseq;
    wb_t e, g;
    bit c;
    push({1'b1, 5'd9, 32'h0000_F00D, 1'b0}, 1'b1);
    push({1'b1, 5'd4, 32'h0000_55AA, 1'b0}, 1'b1);
    push({1'b1, 5'd6, 32'h0000_0077, 1'b0}, 1'b1);
    drive(cw(1'b1, 1'b0, 2'b01, 5'd9, 3'b101), 32'h0, 32'h10, 32'h0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_F00D;
    drive(cw(1'b1, 1'b0, 2'b00, 5'd4, 3'b000), 32'h0000_55AA, 32'h0, 32'h0);
    #1;
    n_cmp++;
    if (stall_ex !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_stall: stall_ex=%b required 0", stall_ex); end
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    drive(cw(1'b1, 1'b0, 2'b00, 5'd6, 3'b000), 32'h0000_0077, 32'h0, 32'h0);
    vseq[3] = valid_mem;
    tick(); idle();
    vseq[2] = valid_mem;
    n_cmp++;
    if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL b2b_req_drop: dmem_req=%b required 0", dmem_req); end
    tick();
    vseq[1] = valid_mem;
    tick();
    vseq[0] = valid_mem;
    n_cmp++;
    if (vseq !== 4'b1110) begin n_bad++; $display("FAIL b2b_valid_seq: got %b required 1110", vseq); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL b2b_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL b2b_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  task automatic test_idle_ack();
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick();
    n_cmp++;
    if (got_q.size() != 0 || dmem_req !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack: results=%0d dmem_req=%b required 0 and 0", got_q.size(), dmem_req);
    end
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    wb_t e, g;
    bit c;
    drive(cw(1'b1, 1'b0, 2'b01, 5'd8, 3'b010), 32'h0, 32'h40, 32'h0);
    tick(); idle();
    n_cmp++;
    if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req: dmem_req=%b required 1", dmem_req); end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({dmem_req, valid_mem, stall_ex} !== 3'b000) begin
      n_bad++; $display("FAIL rstmid_drop: req=%b valid=%b stall=%b required 000", dmem_req, valid_mem, stall_ex);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (got_q.size() != 0) begin n_bad++; $display("FAIL rstmid_abandon: got %0d results required 0", got_q.size()); end
    got_q.delete();
    push({1'b1, 5'd2, 32'h0000_BEEF, 1'b0}, 1'b1);
    drive(cw(1'b1, 1'b0, 2'b00, 5'd2, 3'b000), 32'h0000_BEEF, 32'h0, 32'h0);
    tick(); idle();
    tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rstmid_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); c = care_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.rf !== e.rf || g.rd !== e.rd || g.mis !== e.mis || (c && g.data !== e.data)) begin
        n_bad++; $display("FAIL rstmid_wb: got %h required %h", g, e);
      end
    end
    exp_q.delete(); got_q.delete(); care_q.delete();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_done_low();
    test_load_lb();
    test_loads();
    test_stores();
    test_misaligned();
    test_back_to_back();
    test_idle_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
